// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller: owns PC, IR, accumulator and register file,
// fetches over a request/valid handshake and drives an external combinational ALU.
module instruction_sequencer #(
  parameter int OPCODE_WIDTH   = 4,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int REGISTER_WIDTH = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  output logic [ADDRESS_WIDTH-1:0]              instrAddress,
  output logic                                  instrRequest,
  input  logic                                  instrValid,
  input  logic [OPCODE_WIDTH+ADDRESS_WIDTH-1:0] instrData,
  output logic [OPCODE_WIDTH-1:0]               aluOpCode,
  output logic [REGISTER_WIDTH-1:0]             aluAccumulator,
  output logic [REGISTER_WIDTH-1:0]             aluRegister1,
  input  logic [REGISTER_WIDTH-1:0]             aluResult,
  output logic [REGISTER_WIDTH-1:0]             accumulator,
  output logic                                  busy,
  output logic                                  halted
);
  localparam int DEPTH    = 2 ** ADDRESS_WIDTH;
  localparam int IR_WIDTH = OPCODE_WIDTH + ADDRESS_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_INC   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR    = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ    = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALTED
  } state_t;

  state_t                    state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0]  pc_reg, pc_next;
  logic [IR_WIDTH-1:0]       ir_reg, ir_next;
  logic [REGISTER_WIDTH-1:0] acc_reg, acc_next;
  logic                      reg_we;
  logic [REGISTER_WIDTH-1:0] reg_file [DEPTH];

  logic [OPCODE_WIDTH-1:0]   ir_opcode;
  logic [ADDRESS_WIDTH-1:0]  ir_operand;

  assign ir_opcode  = ir_reg[IR_WIDTH-1:ADDRESS_WIDTH];
  assign ir_operand = ir_reg[ADDRESS_WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      acc_reg   <= acc_next;
    end
  end

  // Register file is cleared by reset, so it lives in flops rather than RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_file[i] <= '0;
      end
    end else if (reg_we) begin
      reg_file[ir_operand] <= acc_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    acc_next   = acc_reg;
    reg_we     = 1'b0;
    case (state_reg)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
        end
      end
      S_FETCH: begin
        if (instrValid) begin
          ir_next    = instrData;
          pc_next    = pc_reg + 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        state_next = S_FETCH;
        case (ir_opcode)
          OP_ADD, OP_INC, OP_AND, OP_OR: acc_next = aluResult;
          OP_LOAD:  acc_next = reg_file[ir_operand];
          OP_STORE: reg_we   = 1'b1;
          OP_JUMP:  pc_next  = ir_operand;
          OP_JZ: begin
            if (acc_reg == '0) pc_next = ir_operand;
          end
          OP_HALT:  state_next = S_HALTED;
          default: ;
        endcase
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign instrAddress   = pc_reg;
  assign instrRequest   = (state_reg == S_FETCH);
  assign aluOpCode      = ir_opcode;
  assign aluAccumulator = acc_reg;
  assign aluRegister1   = reg_file[ir_operand];
  assign accumulator    = acc_reg;
  assign busy           = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                          (state_reg == S_EXECUTE);
  assign halted         = (state_reg == S_HALTED);
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with a behavioural program memory
// and combinational ALU; each check is an immediate assertion.
module tb_instruction_sequencer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] instrAddress;
  logic       instrRequest;
  logic       instrValid;
  logic [7:0] instrData;
  logic [3:0] aluOpCode;
  logic [7:0] aluAccumulator;
  logic [7:0] aluRegister1;
  logic [7:0] aluResult;
  logic [7:0] accumulator;
  logic       busy;
  logic       halted;

  logic [7:0] prog [16];
  logic       valid_en = 1'b1;
  int         checks = 0;
  int         failures = 0;
  int         n;

  instruction_sequencer #(
    .OPCODE_WIDTH(4), .ADDRESS_WIDTH(4), .REGISTER_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .instrAddress(instrAddress), .instrRequest(instrRequest),
    .instrValid(instrValid), .instrData(instrData),
    .aluOpCode(aluOpCode), .aluAccumulator(aluAccumulator),
    .aluRegister1(aluRegister1), .aluResult(aluResult),
    .accumulator(accumulator), .busy(busy), .halted(halted)
  );

  always #5 clock = ~clock;

  assign instrValid = instrRequest & valid_en;
  assign instrData  = prog[instrAddress];

  // Reference ALU; AND is logical (0 or 1).
  always_comb begin
    aluResult = 8'h00;
    case (aluOpCode)
      4'd1: aluResult = aluAccumulator + aluRegister1;
      4'd2: aluResult = aluAccumulator + 8'd1;
      4'd3: aluResult = ((aluAccumulator != 0) && (aluRegister1 != 0)) ? 8'd1 : 8'd0;
      4'd4: aluResult = aluAccumulator | aluRegister1;
      default: aluResult = 8'h00;
    endcase
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic step(input int instrs);
    for (int i = 0; i < 3 * instrs; i++) tick();
  endtask

  task automatic run_to_halt(input int max_cycles, output int cycles);
    cycles = 0;
    while (!halted && cycles < max_cycles) begin
      tick();
      cycles++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    clear_prog();
    #1;
    // Reset state
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_req", {31'd0, instrRequest}, 0);
    check("rst_acc", {24'd0, accumulator}, 0);
    do_reset();
    check("rst_addr", {28'd0, instrAddress}, 0);

    // Three INCREMENTs then HALT: 12 cycles
    prog[0] = 8'h20; prog[1] = 8'h20; prog[2] = 8'h20; prog[3] = 8'hF0;
    pulse_start();
    run_to_halt(100, n);
    check("inc3_cycles", n, 12);
    check("inc3_acc", {24'd0, accumulator}, 3);
    check("inc3_busy", {31'd0, busy}, 0);
    check("inc3_req", {31'd0, instrRequest}, 0);
    // Restart from HALTED keeps accumulator
    prog[0] = 8'hF0;
    pulse_start();
    check("restart_addr", {28'd0, instrAddress}, 0);
    check("restart_busy", {31'd0, busy}, 1);
    run_to_halt(100, n);
    check("restart_acc", {24'd0, accumulator}, 3);

    // STORE then LOAD through r5
    do_reset();
    clear_prog();
    prog[0] = 8'h20; prog[1] = 8'h65; prog[2] = 8'h20; prog[3] = 8'h20;
    prog[4] = 8'h55; prog[5] = 8'hF5;
    pulse_start();
    run_to_halt(100, n);
    check("ld_acc", {24'd0, accumulator}, 1);
    check("ld_reg5", {24'd0, aluRegister1}, 1);
    check("ld_opcode", {28'd0, aluOpCode}, 4'hF);

    // ALU ops: acc=0x0C, r2=0x0A
    do_reset();
    clear_prog();
    for (int i = 0; i < 5; i++) prog[i] = 8'h20;
    prog[5] = 8'h62; prog[6] = 8'h12; prog[7] = 8'h62; prog[8] = 8'h20;
    prog[9] = 8'h20; prog[10] = 8'h12; prog[11] = 8'h42; prog[12] = 8'h32;
    prog[13] = 8'hF0;
    pulse_start();
    step(10);
    check("pre_acc", {24'd0, accumulator}, 8'h0C);
    step(1);
    check("add_acc", {24'd0, accumulator}, 8'h16);
    step(1);
    check("or_acc", {24'd0, accumulator}, 8'h1E);
    step(1);
    check("and_acc", {24'd0, accumulator}, 8'h01);
    run_to_halt(20, n);

    // JZ taken/not taken, JUMP from 15 to 0
    do_reset();
    clear_prog();
    prog[0] = 8'h89; prog[1] = 8'hF0; prog[9] = 8'h20; prog[10] = 8'h89;
    prog[11] = 8'h7F; prog[15] = 8'h70;
    pulse_start();
    step(1);
    check("jz_taken_addr", {28'd0, instrAddress}, 9);
    step(1);
    check("jz_inc_addr", {28'd0, instrAddress}, 10);
    check("jz_inc_acc", {24'd0, accumulator}, 1);
    step(1);
    check("jz_nottaken_addr", {28'd0, instrAddress}, 11);
    step(1);
    check("jump15_addr", {28'd0, instrAddress}, 15);
    step(1);
    check("jump0_addr", {28'd0, instrAddress}, 0);
    step(1);
    check("jz_nt0_addr", {28'd0, instrAddress}, 1);
    run_to_halt(20, n);

    // Fetch stall, then reset in EXECUTE of STORE
    do_reset();
    clear_prog();
    prog[0] = 8'h20; prog[1] = 8'h63;
    valid_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", {31'd0, instrRequest}, 1);
      check("stall_addr", {28'd0, instrAddress}, 0);
    end
    check("stall_acc", {24'd0, accumulator}, 0);
    valid_en = 1'b1;
    step(1);
    check("post_stall_acc", {24'd0, accumulator}, 1);
    check("post_stall_addr", {28'd0, instrAddress}, 1);
    tick();
    tick();
    reset = 1'b1;
    start = 1'b1;
    #1;
    check("async_req", {31'd0, instrRequest}, 0);
    check("async_busy", {31'd0, busy}, 0);
    check("async_halted", {31'd0, halted}, 0);
    check("async_acc", {24'd0, accumulator}, 0);
    check("async_addr", {28'd0, instrAddress}, 0);
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("start_rst_busy", {31'd0, busy}, 0);
    prog[0] = 8'hF3;
    pulse_start();
    run_to_halt(20, n);
    check("store_abandoned", {24'd0, aluRegister1}, 0);

    // Looping increment until wrap; start pulsed while busy
    do_reset();
    clear_prog();
    prog[0] = 8'h20; prog[1] = 8'h83; prog[2] = 8'h70; prog[3] = 8'hF0;
    pulse_start();
    for (int i = 0; i < 2289; i++) begin
      if (i == 100) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("wrap_ff", {24'd0, accumulator}, 8'hFF);
    step(3);
    check("wrap_00", {24'd0, accumulator}, 8'h00);
    check("wrap_busy", {31'd0, busy}, 1);
    run_to_halt(50, n);
    check("wrap_halt_cycles", n, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
